// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  // Bus widths for instruction addresses, instruction words and BHT index.
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int BR_INDEX_W  = 6;

  // Major opcode of conditional branches.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Counters come out of reset weakly not-taken.
  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  // Fetch sequencer: one state per byte of the word, then the output slot.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_OUT  = 3'd5
  } fetch_state_e;

  // Sign-extended B-type immediate; takes inst[31:25] and inst[11:7].
  function automatic logic [INST_ADDR_W-1:0] branch_offset(input logic [6:0] hi,
                                                           input logic [4:0] lo);
    return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one update port. A lookup in the same cycle
// as an update of the same entry returns the pre-update value.
module if_bht
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = BR_INDEX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_index_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_index_i,
  input  logic             upd_taken_i
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_cur;
  logic [1:0] cnt_d;

  assign rd_taken_o = cnt_q[rd_index_i][1];
  assign cnt_cur    = cnt_q[upd_index_i];

  // Saturating increment on taken, decrement on not-taken.
  always_comb begin
    cnt_d = cnt_cur;
    if (upd_taken_i) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'b01;
    end
  end

  // Counter storage: reset all entries, then write back the updated entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_CNT_RESET;
    end else if (upd_en_i) begin
      cnt_q[upd_index_i] <= cnt_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit word from four little-endian
// byte reads, presents it to decode with pc, BHT index and prediction, holds
// it under stall and restarts on redirect.
// Optional macro IF_BHT_EN enables the branch history table and prediction;
// without it prd_jmp_o is 0 and fetch always proceeds sequentially.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int          BHT_IDX_W = BR_INDEX_W,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  input  logic                 upd_en_i,
  input  logic [BHT_IDX_W-1:0] upd_index_i,
  input  logic                 upd_taken_i,
  output logic                 mem_req_o,
  output logic [31:0]          mem_addr_o,
  input  logic                 mem_valid_i,
  input  logic [7:0]           mem_data_i,
  output logic                 valid_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic [BHT_IDX_W-1:0] br_index_o,
  output logic                 prd_jmp_o
);

  fetch_state_e state_q, state_d;

  logic [INST_ADDR_W-1:0] pc_q, pc_d;          // address of the word being fetched
  logic [23:0]            inst_q, inst_d;      // bytes 0..2; byte 3 goes straight out
  logic                   valid_q, valid_d;
  logic [INST_ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [INST_W-1:0]      out_inst_q, out_inst_d;
  logic [BHT_IDX_W-1:0]   out_idx_q, out_idx_d;
  logic                   out_prd_q, out_prd_d;

  logic [BHT_IDX_W-1:0]   fetch_idx;
  logic                   predict_taken;
  logic [INST_ADDR_W-1:0] seq_pc;
  logic [INST_ADDR_W-1:0] next_pc;

  assign fetch_idx = pc_q[BHT_IDX_W+1:2];
  assign seq_pc    = out_pc_q + 32'd4;

`ifdef IF_BHT_EN
  logic bht_taken;

  if_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index_i  (fetch_idx),
    .rd_taken_o  (bht_taken),
    .upd_en_i    (upd_en_i),
    .upd_index_i (upd_index_i),
    .upd_taken_i (upd_taken_i)
  );

  // Opcode sits in byte 0, already captured by the time byte 3 arrives.
  assign predict_taken = (inst_q[6:0] == OPC_BRANCH) && bht_taken;
  assign next_pc = out_prd_q
                 ? out_pc_q + branch_offset(out_inst_q[31:25], out_inst_q[11:7])
                 : seq_pc;
`else
  logic unused_upd;

  assign unused_upd    = ^{upd_en_i, upd_index_i, upd_taken_i, out_prd_q};
  assign predict_taken = 1'b0;
  assign next_pc       = seq_pc;
`endif

  // Next-state logic: redirect wins over everything, then per-state byte collection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    out_idx_d  = out_idx_q;
    out_prd_d  = out_prd_q;
    if (redirect_i) begin
      state_d = ST_B0;
      pc_d    = redirect_pc_i;
      inst_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_B0;
        ST_B0: if (mem_valid_i) begin
          inst_d[7:0] = mem_data_i;
          state_d     = ST_B1;
        end
        ST_B1: if (mem_valid_i) begin
          inst_d[15:8] = mem_data_i;
          state_d      = ST_B2;
        end
        ST_B2: if (mem_valid_i) begin
          inst_d[23:16] = mem_data_i;
          state_d       = ST_B3;
        end
        ST_B3: if (mem_valid_i) begin
          state_d    = ST_OUT;
          valid_d    = 1'b1;
          out_pc_d   = pc_q;
          out_inst_d = {mem_data_i, inst_q};
          out_idx_d  = fetch_idx;
          out_prd_d  = predict_taken;
        end
        ST_OUT: if (!stall_i) begin
          state_d = ST_B0;
          valid_d = 1'b0;
          pc_d    = next_pc;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      out_idx_q  <= '0;
      out_prd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      out_idx_q  <= out_idx_d;
      out_prd_q  <= out_prd_d;
    end
  end

  // Memory request decoded from the byte states; silent in IDLE and OUT.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    case (state_q)
      ST_B0: begin mem_req_o = 1'b1; mem_addr_o = pc_q;          end
      ST_B1: begin mem_req_o = 1'b1; mem_addr_o = pc_q + 32'd1;  end
      ST_B2: begin mem_req_o = 1'b1; mem_addr_o = pc_q + 32'd2;  end
      ST_B3: begin mem_req_o = 1'b1; mem_addr_o = pc_q + 32'd3;  end
      default: ;
    endcase
  end

  assign valid_o    = valid_q;
  assign pc_o       = out_pc_q;
  assign inst_o     = out_inst_q;
  assign br_index_o = out_idx_q;
  assign prd_jmp_o  = out_prd_q;

endmodule
